// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: one request channel in, one result channel out.
// Valid/ready: a transfer happens on a rising edge where the producer's valid and the consumer's ready are both high.
// A producer that raises valid keeps the payload stable until that edge.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             InValid;
  logic             InReady;
  logic [2:0]       Sel;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] DataOut;
  logic             Zero;
  logic             Cout;
  logic             Overflow;

  modport master (
    output InValid, Sel, DataA, DataB, OutReady,
    input  InReady, OutValid, DataOut, Zero, Cout, Overflow
  );

  modport slave (
    input  InValid, Sel, DataA, DataB, OutReady,
    output InReady, OutValid, DataOut, Zero, Cout, Overflow
  );
endinterface

// File: rtl/alu_pipe.sv
// EX-stage ALU with a registered result, flags and valid/ready on both sides.
// Logic/add/sub/slt complete in one cycle; MUL is a WIDTH-cycle shift-add loop.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus,
  output logic       dbgState
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } stateT;

  stateT state;
  stateT nextState;

  logic inReady;
  logic consume;
  logic loadSingle;
  logic startMul;
  logic mulStep;
  logic mulDone;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] accStep;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] dataOutQ;
  logic             outValidQ;
  logic             zeroQ;
  logic             coutQ;
  logic             overflowQ;

  logic [WIDTH:0]   sumExt;
  logic [WIDTH:0]   diffExt;
  logic             addOvf;
  logic             subOvf;
  logic [WIDTH-1:0] aluRes;
  logic             aluCout;
  logic             aluOvf;

  assign consume = outValidQ && bus.OutReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // The last iteration waits while an older result is still unconsumed,
  // so the counter parks at 1 instead of overwriting the output slot.
  always_comb begin
    nextState  = state;
    inReady    = 1'b0;
    loadSingle = 1'b0;
    startMul   = 1'b0;
    mulStep    = 1'b0;
    mulDone    = 1'b0;
    case (state)
      IDLE: begin
        inReady = !outValidQ || bus.OutReady;
        if (bus.InValid && inReady) begin
          if (bus.Sel == OP_MUL) begin
            startMul  = 1'b1;
            nextState = MUL;
          end else begin
            loadSingle = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt == CNT_W'(1)) begin
          if (!(outValidQ && !bus.OutReady)) begin
            mulStep   = 1'b1;
            mulDone   = 1'b1;
            nextState = IDLE;
          end
        end else begin
          mulStep = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // SUB is A + ~B + 1, so its carry out is the unsigned no-borrow flag.
  assign sumExt  = {1'b0, bus.DataA} + {1'b0, bus.DataB};
  assign diffExt = {1'b0, bus.DataA} + {1'b0, ~bus.DataB} + (WIDTH+1)'(1);
  assign addOvf  = (bus.DataA[WIDTH-1] == bus.DataB[WIDTH-1]) &&
                   (sumExt[WIDTH-1] != bus.DataA[WIDTH-1]);
  assign subOvf  = (bus.DataA[WIDTH-1] != bus.DataB[WIDTH-1]) &&
                   (diffExt[WIDTH-1] != bus.DataA[WIDTH-1]);

  always_comb begin
    aluRes  = '0;
    aluCout = 1'b0;
    aluOvf  = 1'b0;
    case (bus.Sel)
      OP_AND: aluRes = bus.DataA & bus.DataB;
      OP_OR:  aluRes = bus.DataA | bus.DataB;
      OP_XOR: aluRes = bus.DataA ^ bus.DataB;
      OP_NOR: aluRes = ~(bus.DataA | bus.DataB);
      OP_ADD: begin
        aluRes  = sumExt[WIDTH-1:0];
        aluCout = sumExt[WIDTH];
        aluOvf  = addOvf;
      end
      OP_SUB: begin
        aluRes  = diffExt[WIDTH-1:0];
        aluCout = diffExt[WIDTH];
        aluOvf  = subOvf;
      end
      OP_SLT: aluRes = {{(WIDTH-1){1'b0}}, diffExt[WIDTH-1] ^ subOvf};
      default: aluRes = '0;
    endcase
  end

  assign accStep = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (startMul) begin
      mcand  <= bus.DataA;
      mplier <= bus.DataB;
      acc    <= '0;
      cnt    <= CNT_W'(WIDTH);
    end else if (mulStep) begin
      acc    <= accStep;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

  // A load on the same edge as a consume keeps OutValid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOutQ  <= '0;
      outValidQ <= 1'b0;
      zeroQ     <= 1'b0;
      coutQ     <= 1'b0;
      overflowQ <= 1'b0;
    end else if (loadSingle) begin
      dataOutQ  <= aluRes;
      outValidQ <= 1'b1;
      zeroQ     <= (aluRes == '0);
      coutQ     <= aluCout;
      overflowQ <= aluOvf;
    end else if (mulDone) begin
      dataOutQ  <= accStep;
      outValidQ <= 1'b1;
      zeroQ     <= (accStep == '0);
      coutQ     <= 1'b0;
      overflowQ <= 1'b0;
    end else if (consume) begin
      outValidQ <= 1'b0;
    end
  end

  assign bus.InReady  = inReady;
  assign bus.OutValid = outValidQ;
  assign bus.DataOut  = dataOutQ;
  assign bus.Zero     = zeroQ;
  assign bus.Cout     = coutQ;
  assign bus.Overflow = overflowQ;
  assign dbgState     = state;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised N-bit ALU with a registered result and a valid/ready handshake on both input and output.
- Single-cycle ops: AND, OR, XOR, NOR, ADD, SUB, SLT.
- MUL is an iterative shift-add unsigned multiply that holds the unit busy for WIDTH cycles.
- Sits in the EX stage of the pipelined datapath. It replaces the ripple chain of 1-bit ALU slices, adds flags, and supports stalls.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- InValid  input  1  operands and Sel valid this cycle
- InReady  output  1  unit can accept a new operation
- Sel  input  3  op: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 MUL, 110 SUB, 111 SLT
- DataA  input  WIDTH  operand A
- DataB  input  WIDTH  operand B
- OutValid  output  1  result registers hold an unconsumed result
- OutReady  input  1  downstream consumes the result this cycle
- DataOut  output  WIDTH  result
- Zero  output  1  DataOut == 0
- Cout  output  1  carry out (ADD), no-borrow (SUB: 1 when A>=B unsigned), 0 otherwise
- Overflow  output  1  signed overflow (ADD/SUB only), 0 otherwise

Behaviour:
- Reset (rst_n low, async): state IDLE; DataOut=0, Zero=0, Cout=0, Overflow=0, OutValid=0; counter and multiply accumulators cleared. Reset mid-MUL aborts the op with no output.
- Clock and reset are the only timing inputs: one clock, asynchronous active-low reset.
- InReady = (state==IDLE) && (!OutValid || OutReady). It is combinational and depends on OutReady.
- Accept condition: InValid && InReady at a rising edge. Sel, DataA and DataB are sampled only then.
- Output consume: OutValid && OutReady at an edge. If a new result is loaded on the same edge, OutValid stays 1; otherwise it clears.
- Single-cycle ops:
  - Result, flags and OutValid=1 are registered on the accept edge, so latency is 1 cycle. Back-to-back issue runs at 1 op/cycle while OutReady=1.
  - SUB = A + ~B + 1.
  - Overflow for ADD: sign(A)==sign(B) and sign(sum)!=sign(A). For SUB: sign(A)!=sign(B) and sign(diff)!=sign(A).
  - SLT = {0..., 1} if signed A < signed B, computed as diff_sign XOR overflow. Cout and Overflow are 0 for SLT.
  - Logic ops: Cout=0, Overflow=0.
- MUL state machine: IDLE -> MUL on accept with Sel==101. The multiplicand, multiplier and accumulator (WIDTH bits) are latched and the counter is set to WIDTH.
  - In MUL, each edge: if multiplier LSB is set, acc += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; counter--.
  - When the counter reaches 1 on an edge, that same edge loads DataOut = final acc (low WIDTH bits of A*B, unsigned), sets OutValid=1, Cout=0, Overflow=0, and returns to IDLE.
  - A MUL accepted at edge k presents its result after edge k+WIDTH.
- MUL holds InReady=0 for the whole MUL state. While in MUL, OutValid may still hold the previous result and be consumed normally.
- The MUL entry edge requires InReady, which requires the output slot to be free or drained. Because an earlier result may still be pending when the iterations finish, the final MUL edge is blocked while (OutValid && !OutReady); the state stays in MUL with the counter held at 1.
- Zero is always registered together with DataOut.
- Sel is fully decoded; no illegal codes exist.
- Outputs hold when OutValid=0 (stale values are not cleared).

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> OutValid, DataOut, flags all 0 immediately; InReady=1 after release with OutReady=1.
- WIDTH=8, ADD 0x7F+0x01 -> DataOut=0x80, Overflow=1, Cout=0, Zero=0, 1 cycle after accept. ADD 0xFF+0x01 -> 0x00, Cout=1, Zero=1, Overflow=0.
- WIDTH=8, SUB 0x80-0x01 -> 0x7F, Overflow=1, Cout=1. SLT 0x80,0x01 -> 0x01. SLT 0x01,0x80 -> 0x00. AND/OR/XOR/NOR 0xCC,0xAA -> 0x88/0xEE/0x66/0x11.
- WIDTH=8, MUL 13*11 accepted at edge k -> InReady=0 for 8 cycles; DataOut=0x8F, OutValid=1 after edge k+8. MUL 0x10*0x20 -> 0x00, Zero=1.
- Backpressure: OutReady=0 with a result pending -> InReady=0, DataOut stable. Raise OutReady while issuing ADD -> next result loaded, OutValid stays 1, no result lost or duplicated over a 100-op random stream checked against a model.
- Reset during MUL at iteration 4 -> no OutValid; the next op after release completes correctly.
